// File: rtl/edge_detect_pipe.sv
// Three-stage streaming 3x3 Sobel edge detector with valid/ready on both sides.
// Optional EDGE_DIR_EN adds the 2-bit edge direction output oDir.
module edge_detect_pipe #(
    parameter int PIX_W = 8,
    parameter int MODE  = 0,
    localparam int GW   = PIX_W + 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9*PIX_W-1:0] iGrid,
    input  logic [GW-1:0]      iThreshold,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               isEdge,
    output logic [GW-1:0]      oMag
`ifdef EDGE_DIR_EN
    ,
    output logic [1:0]         oDir
`endif
);

    localparam int SW = PIX_W + 2;

    generate
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("edge_detect_pipe: MODE must be 0 (L1) or 1 (MAX)");
        end
    endgenerate

    logic [PIX_W-1:0] w_p [9];
    logic             w_rdy1, w_rdy2, w_rdy3;
    logic             r_v1, r_v2, r_v3;

    logic [SW-1:0]    r_col_a, r_col_b, r_row_t, r_row_b;
    logic [GW-1:0]    r_thr1, r_thr2;
    logic [GW-2:0]    r_ax, r_ay;

    logic signed [GW-1:0] w_gx, w_gy;
    logic [GW-2:0]        w_ax, w_ay;
    logic [GW:0]          w_sum;
    logic [GW-1:0]        w_l1, w_max, w_mag;

    function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_p[k] = iGrid[k*PIX_W +: PIX_W];
        end
    end

    // A stage may load when it is empty or the stage after it is moving.
    assign w_rdy3    = !r_v3 || out_ready;
    assign w_rdy2    = !r_v2 || w_rdy3;
    assign w_rdy1    = !r_v1 || w_rdy2;
    assign in_ready  = w_rdy1;
    assign out_valid = r_v3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_col_a <= '0;
            r_col_b <= '0;
            r_row_t <= '0;
            r_row_b <= '0;
            r_thr1  <= '0;
        end else if (w_rdy1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_col_a <= wsum(w_p[0], w_p[3], w_p[6]);
                r_col_b <= wsum(w_p[2], w_p[5], w_p[8]);
                r_row_t <= wsum(w_p[0], w_p[1], w_p[2]);
                r_row_b <= wsum(w_p[6], w_p[7], w_p[8]);
                r_thr1  <= iThreshold;
            end
        end
    end

    assign w_gx = $signed({1'b0, r_col_a}) - $signed({1'b0, r_col_b});
    assign w_gy = $signed({1'b0, r_row_b}) - $signed({1'b0, r_row_t});
    // |g| never exceeds 4*(2^PIX_W-1), so GW-1 bits hold it exactly.
    assign w_ax = w_gx[GW-1] ? (~w_gx[GW-2:0] + (GW-1)'(1)) : w_gx[GW-2:0];
    assign w_ay = w_gy[GW-1] ? (~w_gy[GW-2:0] + (GW-1)'(1)) : w_gy[GW-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_ax   <= '0;
            r_ay   <= '0;
            r_thr2 <= '0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_ax   <= w_ax;
                r_ay   <= w_ay;
                r_thr2 <= r_thr1;
            end
        end
    end

`ifdef EDGE_DIR_EN
    logic       r_sx, r_sy;
    logic [1:0] w_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sx <= 1'b0;
            r_sy <= 1'b0;
        end else if (w_rdy2 && r_v1) begin
            r_sx <= w_gx[GW-1];
            r_sy <= w_gy[GW-1];
        end
    end

    always_comb begin
        w_dir = 2'b11;
        if ({1'b0, r_ax} >= {r_ay, 1'b0}) begin
            w_dir = 2'b00;
        end else if ({1'b0, r_ay} >= {r_ax, 1'b0}) begin
            w_dir = 2'b01;
        end else if (r_sx == r_sy) begin
            w_dir = 2'b10;
        end
    end
`endif

    assign w_sum = {2'b00, r_ax} + {2'b00, r_ay};
    assign w_l1  = w_sum[GW] ? {GW{1'b1}} : w_sum[GW-1:0];
    assign w_max = {1'b0, (r_ax >= r_ay) ? r_ax : r_ay};
    assign w_mag = (MODE == 1) ? w_max : w_l1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            oMag   <= '0;
            isEdge <= 1'b0;
`ifdef EDGE_DIR_EN
            oDir   <= 2'b00;
`endif
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                oMag   <= w_mag;
                isEdge <= (w_mag > r_thr2);
`ifdef EDGE_DIR_EN
                oDir   <= w_dir;
`endif
            end
        end
    end

endmodule

// File: tb/tb_edge_detect_pipe.sv
// Directed bench for edge_detect_pipe: one L1 and one MAX instance share the stimulus.
// Build with EDGE_DIR_EN defined to also check oDir.
module tb_edge_detect_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] iGrid;
    logic [10:0] iThreshold;
    logic        in_valid, out_ready;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, isEdge0, isEdge1;
    logic [10:0] oMag0, oMag1;
`ifdef EDGE_DIR_EN
    logic [1:0]  oDir0, oDir1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    edge_detect_pipe #(.PIX_W(8), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .iGrid(iGrid), .iThreshold(iThreshold),
        .in_valid(in_valid), .in_ready(in_ready0), .out_valid(out_valid0),
        .out_ready(out_ready), .isEdge(isEdge0), .oMag(oMag0)
`ifdef EDGE_DIR_EN
        , .oDir(oDir0)
`endif
    );

    edge_detect_pipe #(.PIX_W(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .iGrid(iGrid), .iThreshold(iThreshold),
        .in_valid(in_valid), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_ready(out_ready), .isEdge(isEdge1), .oMag(oMag1)
`ifdef EDGE_DIR_EN
        , .oDir(oDir1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] g9(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // One grid through an otherwise empty pipe; result must show exactly 3 cycles later.
    task automatic run_single(input string tag, input logic [71:0] g, input int thr,
                              input int m0, input int e0, input int m1, input int e1,
                              input int dr);
        @(posedge clk); #1;
        iGrid = g; iThreshold = 11'(thr); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " valid@1"}, out_valid0, 0);
        @(negedge clk);
        check({tag, " valid@2"}, out_valid0, 0);
        @(negedge clk);
        check({tag, " valid@3"}, out_valid0, 1);
        check({tag, " valid@3 max"}, out_valid1, 1);
        check({tag, " mag L1"}, oMag0, m0);
        check({tag, " edge L1"}, isEdge0, e0);
        check({tag, " mag MAX"}, oMag1, m1);
        check({tag, " edge MAX"}, isEdge1, e1);
`ifdef EDGE_DIR_EN
        check({tag, " dir L1"}, oDir0, dr);
        check({tag, " dir MAX"}, oDir1, dr);
`endif
    endtask

    logic [71:0] bp_g [6];
    int bp_m0 [6] = '{20, 40, 60, 80, 100, 120};
    int bp_e0 [6] = '{0, 1, 1, 1, 1, 1};
    int bp_m1 [6] = '{10, 20, 30, 40, 50, 60};
    int bp_e1 [6] = '{0, 0, 1, 1, 1, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, oc, seen;
        logic stall_prev;
        logic [10:0] hold0, hold1;
        logic hold_e0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        iGrid = '0; iThreshold = '0;
        #3;
        check("reset out_valid", out_valid0, 0);
        check("reset oMag", oMag0, 0);
        check("reset isEdge", isEdge0, 0);
        check("reset in_ready", in_ready0, 1);
`ifdef EDGE_DIR_EN
        check("reset oDir", oDir0, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        run_single("flat",     g9(100,100,100,100,100,100,100,100,100), 0,   0,    0, 0,    0, 0);
        run_single("leftcol",  g9(255,0,0,255,0,0,255,0,0),             100, 1020, 1, 1020, 1, 0);
        run_single("p0 thr20", g9(10,0,0,0,0,0,0,0,0),                  20,  20,   0, 10,   0, 3);
        run_single("p0 thr19", g9(10,0,0,0,0,0,0,0,0),                  19,  20,   1, 10,   0, 3);
        run_single("p0 thr10", g9(10,0,0,0,0,0,0,0,0),                  10,  20,   1, 10,   0, 3);
        run_single("toprow",   g9(200,200,200,0,0,0,0,0,0),             799, 800,  1, 800,  1, 1);
        run_single("diag",     g9(0,0,0,0,0,0,10,0,0),                  15,  20,   1, 10,   0, 2);

        // Backpressure: six grids offered back-to-back, consumer stalls cycles 2..7.
        for (int i = 0; i < 6; i++) bp_g[i] = g9(10*(i+1), 0, 0, 0, 0, 0, 0, 0, 0);
        acc = 0; oc = 0; stall_prev = 1'b0;
        hold0 = '0; hold1 = '0; hold_e0 = 1'b0;
        for (int c = 0; c < 40 && oc < 6; c++) begin
            @(posedge clk); #1;
            out_ready  = !(c >= 2 && c <= 7);
            iThreshold = 11'd25;
            if (acc < 6) begin
                in_valid = 1'b1;
                iGrid    = bp_g[acc];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) check("bp in_ready c2", in_ready0, 1);
            if (c == 3) check("bp in_ready c3", in_ready0, 0);
            if (c == 7) check("bp in_ready c7", in_ready0, 0);
            if (c == 8) check("bp in_ready c8", in_ready0, 1);
            if (stall_prev) begin
                check("bp hold valid", out_valid0, 1);
                check("bp hold mag L1", oMag0, hold0);
                check("bp hold edge L1", isEdge0, hold_e0);
                check("bp hold mag MAX", oMag1, hold1);
            end
            if (out_valid0 && out_ready) begin
                check("bp mag L1", oMag0, bp_m0[oc]);
                check("bp edge L1", isEdge0, bp_e0[oc]);
                check("bp mag MAX", oMag1, bp_m1[oc]);
                check("bp edge MAX", isEdge1, bp_e1[oc]);
                oc++;
            end
            stall_prev = out_valid0 && !out_ready;
            hold0 = oMag0; hold1 = oMag1; hold_e0 = isEdge0;
            if (in_valid && in_ready0) acc++;
        end
        check("bp accepted", acc, 6);
        check("bp results", oc, 6);

        // Mid-stream reset with three grids in flight.
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; iThreshold = '0;
        for (int i = 0; i < 3; i++) begin
            iGrid    = g9(50*(i+1), 0, 0, 50*(i+1), 0, 0, 50*(i+1), 0, 0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst inflight valid", out_valid0, 1);
        rst = 1'b1;
        #1;
        check("rst out_valid", out_valid0, 0);
        check("rst oMag", oMag0, 0);
        check("rst isEdge", isEdge0, 0);
        check("rst out_valid MAX", out_valid1, 0);
        check("rst oMag MAX", oMag1, 0);
        check("rst in_ready", in_ready0, 1);
        check("rst in_ready MAX", in_ready1, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen += int'(out_valid0) + int'(out_valid1);
        end
        check("rst no ghost results", seen, 0);
        run_single("post rst", g9(10,0,0,0,0,0,0,0,0), 19, 20, 1, 10, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detect_pipe.md
Name: edge_detect_pipe

Overview:
- Streaming, pipelined 3x3 Sobel edge detector. Successor to the single-cycle 8-bit edge flag block.
- Adds a parametrised pixel width and full-precision gradient arithmetic with no wrap-around.
- Adds a selectable magnitude mode, a registered gradient magnitude output, and valid/ready handshakes on both sides.
- Sits between the 3x3 window buffer and the cartoon compositor.

Parameters:
PIX_W, 8, bits per pixel intensity.
MODE, 0, magnitude metric: 0 = L1 (|gx|+|gy|), 1 = MAX (max(|gx|,|gy|)).
Derived localparam GW = PIX_W+3, width of the signed gradient and of the unsigned magnitude.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
iGrid  in  9*PIX_W  3x3 window; pixel k at [k*PIX_W +: PIX_W]; k=0..2 top row, k=6..8 bottom row, k=0/3/6 first column.
iThreshold  in  GW  edge threshold, unsigned; sampled with the grid at stage 1.
in_valid  in  1  iGrid/iThreshold valid.
in_ready  out  1  block can accept this cycle.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
isEdge  out  1  1 = edge.
oMag  out  GW  gradient magnitude.

Behaviour:
- Transfer on each side occurs when valid && ready.
- Three register stages, S1..S3, each with its own valid bit v1..v3.
- Stage k loads when ready_k = !v_k || ready_{k+1}; ready_4 = out_ready. in_ready = ready_1, combinational.
- Latency is 3 cycles from input transfer to out_valid with no backpressure. Throughput is 1 grid per cycle.
- S1: register colA = p0+2p3+p6, colB = p2+2p5+p8, rowT = p0+2p1+p2, rowB = p6+2p7+p8, each PIX_W+2 bits unsigned. Register the threshold alongside.
- S2: register gx = colA-colB and gy = rowB-rowT, signed, GW bits. Register ax=|gx|, ay=|gy|, GW-1 bits, and the sign bits.
- S3, MODE=0: mag = ax+ay, GW bits, saturating at 2^GW-1. Saturation is unreachable by construction, but it is still required.
- S3, MODE=1: mag = max(ax, ay), zero-extended.
- S3 registers oMag = mag and isEdge = (mag > threshold). The comparison is strict.
- Outputs hold stable while out_valid && !out_ready. No data loss or duplication under any ready pattern. Order is preserved.
- Holding stages with valid=0 keep their data (don't-care). Only valid bits gate progress.
- Reset, including assertion mid-stream:
  - v1..v3 = 0, out_valid = 0, isEdge = 0, oMag = 0 immediately.
  - In-flight grids are discarded.
  - in_ready = 1 while rst is high.
  - The first accepted grid after deassertion appears 3 cycles later.
- MODE is invalid unless it is 0 or 1; an elaboration-time check errors.

Optional Feature:
- Macro EDGE_DIR_EN adds output port oDir, out, 2 bits, registered in S3 and held with the other outputs. Encoding:
  - 00: ax >= 2*ay (vertical edge).
  - 01: ay >= 2*ax and not 00 (horizontal edge).
  - 10: otherwise, when sign(gx)==sign(gy) (diagonal).
  - 11: otherwise, when the signs differ (anti-diagonal).
- A zero gradient (gx=gy=0) encodes 00.
- Reset value of oDir is 00.
- Without the macro, oDir and the sign-bit pipeline registers do not exist. All other behaviour is identical.

Test Plan:
1. PIX_W=8, MODE=0, all pixels 100, thr 0, out_ready=1 -> 3 cycles later out_valid=1, oMag=0, isEdge=0.
2. p0=p3=p6=255, others 0, thr 100, both modes -> gx=1020, gy=0, oMag=1020 (no 8-bit wrap), isEdge=1.
3. p0=10, others 0 (gx=10, gy=-10):
   - MODE=0, thr 20 -> oMag=20, isEdge=0.
   - MODE=0, thr 19 -> isEdge=1.
   - MODE=1, thr 10 -> oMag=10, isEdge=0.
4. Backpressure: feed 6 distinct grids back-to-back, out_ready=0 for cycles 2..7 -> in_ready falls after 3 grids are buffered; all 6 results emerge in order, each held stable while stalled.
5. Reset: assert rst for 1 cycle while 3 grids are in flight -> out_valid=0, isEdge=0, oMag=0 at once; none of the 3 results ever appear; a new grid after release produces its result 3 cycles later.
6. EDGE_DIR_EN defined:
   - Vector 3 -> oDir=11.
   - p0=p1=p2=200, others 0 -> gy=-800, gx=0, oDir=01.
   - Vector 2 -> oDir=00.
